// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode/control stage: one instruction per cycle in, one decoded control bundle out.
// Optional feature macro: ILLEGAL_TRAP_EN adds the registered 'illegal' output flag.
module decode_ctrl_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  ALUsrc,
  output logic                  Branch,
  output logic                  BranchNe,
  output logic                  Jump,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ALUctrl,
  output logic [2:0]            ImmSrc,
  output logic [DATA_WIDTH-1:0] ImmExt,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  illegal
`endif
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic       d_regwrite, d_memwrite, d_alusrc, d_branch, d_branchne, d_jump, d_illegal;
  logic [1:0] d_resultsrc;
  logic [2:0] d_aluctrl, d_immsrc;
  logic [31:0] imm32;
  logic [DATA_WIDTH-1:0] d_immext;

  always_comb begin
    d_regwrite  = 1'b0;
    d_memwrite  = 1'b0;
    d_alusrc    = 1'b0;
    d_branch    = 1'b0;
    d_branchne  = 1'b0;
    d_jump      = 1'b0;
    d_resultsrc = 2'b00;
    d_aluctrl   = ALU_ADD;
    d_immsrc    = IMM_I;
    d_illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        d_regwrite = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: d_aluctrl = ALU_ADD;
          {7'b0100000, 3'b000}: d_aluctrl = ALU_SUB;
          {7'b0000000, 3'b111}: d_aluctrl = ALU_AND;
          {7'b0000000, 3'b110}: d_aluctrl = ALU_OR;
          {7'b0000000, 3'b010}: d_aluctrl = ALU_SLT;
          default:              d_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        case (funct3)
          3'b000:  d_aluctrl = ALU_ADD;
          3'b111:  d_aluctrl = ALU_AND;
          3'b110:  d_aluctrl = ALU_OR;
          3'b010:  d_aluctrl = ALU_SLT;
          default: d_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d_regwrite  = 1'b1;
        d_alusrc    = 1'b1;
        d_resultsrc = 2'b01;
        d_illegal   = (funct3 != 3'b010);
      end
      OP_STORE: begin
        d_memwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_immsrc   = IMM_S;
        d_illegal  = (funct3 != 3'b010);
      end
      OP_BR: begin
        d_branch   = 1'b1;
        d_branchne = (funct3 == 3'b001);
        d_aluctrl  = ALU_SUB;
        d_immsrc   = IMM_B;
        d_illegal  = (funct3 != 3'b000) && (funct3 != 3'b001);
      end
      OP_JAL: begin
        d_jump      = 1'b1;
        d_regwrite  = 1'b1;
        d_resultsrc = 2'b10;
        d_immsrc    = IMM_J;
      end
      default: d_illegal = 1'b1;
    endcase
    // Unsupported encodings leave the stage as harmless bubbles.
    if (d_illegal) begin
      d_regwrite  = 1'b0;
      d_memwrite  = 1'b0;
      d_alusrc    = 1'b0;
      d_branch    = 1'b0;
      d_branchne  = 1'b0;
      d_jump      = 1'b0;
      d_resultsrc = 2'b00;
      d_aluctrl   = ALU_ADD;
      d_immsrc    = IMM_I;
    end
  end

  always_comb begin
    imm32 = {{20{instr[31]}}, instr[31:20]};
    case (d_immsrc)
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end
  assign d_immext = DATA_WIDTH'($signed(imm32));

  // Handshake: a transfer happens on a rising edge where valid && ready; the producer keeps its
  // payload stable while valid && !ready. Here the register accepts when empty or being drained.
  logic capture;
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
      ALUsrc    <= 1'b0;
      Branch    <= 1'b0;
      BranchNe  <= 1'b0;
      Jump      <= 1'b0;
      ResultSrc <= 2'b00;
      ALUctrl   <= 3'b000;
      ImmSrc    <= 3'b000;
      ImmExt    <= '0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal   <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_pc    <= pc;
      RegWrite  <= d_regwrite;
      MemWrite  <= d_memwrite;
      ALUsrc    <= d_alusrc;
      Branch    <= d_branch;
      BranchNe  <= d_branchne;
      Jump      <= d_jump;
      ResultSrc <= d_resultsrc;
      ALUctrl   <= d_aluctrl;
      ImmSrc    <= d_immsrc;
      ImmExt    <= d_immext;
      rs1       <= instr[19:15];
      rs2       <= instr[24:20];
      rd        <= instr[11:7];
`ifdef ILLEGAL_TRAP_EN
      illegal   <= d_illegal;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
